uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  Serial transmitter for the memory-side UART link; the other end of the UART receive block.
//  Buffers bytes in a small FIFO and serialises each as a 10-bit frame on o_tx:
//  start(0), 8 data bits, stop(1).
//  Default timing (1 clk/bit, MSB first on the wire) matches the UART receive block, so a loopback returns the same bytes.
// PARAMETERS
//  CLKS_PER_BIT  1   clocks each serial bit is held on o_tx (>=1)
//  FIFO_DEPTH    4   byte FIFO entries (power of two, >=2)
//  MSB_FIRST     1   1: data bit 7 sent first; 0: bit 0 sent first
// PORTS
//  i_clk_uart    in   1    single clock, all logic on rising edge
//  i_rst_n       in   1    asynchronous active-low reset
//  i_data        in   8    byte to send
//  i_valid       in   1    i_data valid; write occurs when i_valid & o_ready
//  o_ready       out  1    FIFO not full (combinational from count)
//  o_tx          out  1    serial line, registered, idles high
//  o_busy        out  1    FSM not in IDLE
//  o_done        out  1    1-cycle pulse on last cycle of each stop bit
//  o_fifo_count  out  $clog2(FIFO_DEPTH+1)  bytes waiting (excludes byte in flight)
// BEHAVIOUR
//  Reset (async, any time incl. mid-frame): o_tx=1, o_busy=0, o_done=0, o_fifo_count=0, o_ready=1,
//   FSM=IDLE, FIFO pointers/bit/clk counters cleared; in-flight and queued bytes discarded.
//  FIFO: write on edge when i_valid&o_ready; o_ready=(count!=FIFO_DEPTH); i_valid while full ignored.
//   Same-edge write and pop: count unchanged. Pointers wrap modulo FIFO_DEPTH. Order strictly FIFO.
//  FSM states IDLE, START, DATA, STOP; clk_cnt counts 0..CLKS_PER_BIT-1 within each bit.
//   IDLE: o_tx=1. If FIFO non-empty at an edge: pop into shift reg, ->START, o_tx=0 from that edge.
//   START: hold o_tx=0 for CLKS_PER_BIT clocks, then ->DATA, drive first data bit.
//   DATA: each bit held CLKS_PER_BIT clocks; bit_cnt 0..7; after bit 7 ->STOP, o_tx=1.
//   STOP: o_tx=1 for CLKS_PER_BIT clocks; o_done=1 in its final cycle. At its end: FIFO non-empty ->
//    pop, ->START (back-to-back, no idle gap); else ->IDLE.
//  Latency: byte written at edge k into empty FIFO while IDLE -> o_tx low from edge k+1.
//  Frame length exactly 10*CLKS_PER_BIT clocks; sustained rate 1 byte / 10*CLKS_PER_BIT clocks.
//  A byte written during a frame never alters the frame in progress (shift reg loaded only on pop).
//  Illegal FSM encoding -> IDLE with o_tx=1.
// TESTING
//  1. CLKS_PER_BIT=1, write 0xA5 at idle -> o_tx from next edge: 0,1,0,1,0,0,1,0,1,1 then 1; o_done once.
//  2. MSB_FIRST=0, write 0xA5 -> o_tx: 0,1,0,1,0,0,1,0,1,1 (LSB first, same for palindrome); repeat 0x01 -> 0,1,0,0,0,0,0,0,0,1.
//  3. Write 0x00,0xFF back-to-back -> 20 contiguous bit-cycles, no idle high between frames; 2 o_done pulses.
//  4. FIFO_DEPTH=4, hold i_valid with 6 bytes 0x10..0x15 -> o_ready low when count=4; all 6 sent in order.
//  5. CLKS_PER_BIT=4, assert i_rst_n=0 mid data bit 3 -> o_tx=1 immediately, count=0; no o_done; next write sends a clean frame.
//  6. Loopback o_tx into UART receive block, CLKS_PER_BIT=1, send 0x3C,0xC3 -> its o_data/o_valid report 0x3C then 0xC3.

Source files
------------

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - byte FIFO plus start/8-data/stop serialiser for the memory-side UART link
module uart_tx #(
  parameter int CLKS_PER_BIT = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int MSB_FIRST    = 1
) (
  input  logic                               i_clk_uart,
  input  logic                               i_rst_n,
  input  logic [7:0]                         i_data,
  input  logic                               i_valid,
  output logic                               o_ready,
  output logic                               o_tx,
  output logic                               o_busy,
  output logic                               o_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CLK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [1:0]       state;
  logic [CLK_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             tx_q;

  logic       push;
  logic       pop;
  logic       bit_end;
  logic       next_bit;
  logic [7:0] shreg_shifted;

  assign bit_end = (clk_cnt == CLK_LAST);
  assign push    = i_valid && o_ready;
  // Pop either from idle or at the very end of a stop bit, giving back-to-back frames.
  assign pop     = (count != '0) &&
                   ((state == S_IDLE) || ((state == S_STOP) && bit_end));

  assign next_bit      = (MSB_FIRST != 0) ? shreg[7] : shreg[0];
  assign shreg_shifted = (MSB_FIRST != 0) ? {shreg[6:0], 1'b0} : {1'b0, shreg[7:1]};

  assign o_ready      = (count != FULL);
  assign o_tx         = tx_q;
  assign o_busy       = (state != S_IDLE);
  assign o_done       = (state == S_STOP) && bit_end;
  assign o_fifo_count = count;

  always_ff @(posedge i_clk_uart) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk_uart or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk_uart or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          clk_cnt <= '0;
          tx_q    <= 1'b1;
          if (pop) begin
            shreg <= mem[rd_ptr];
            state <= S_START;
            tx_q  <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            state   <= S_DATA;
            tx_q    <= next_bit;
            shreg   <= shreg_shifted;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state <= S_STOP;
              tx_q  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_q    <= next_bit;
              shreg   <= shreg_shifted;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (pop) begin
              shreg <= mem[rd_ptr];
              state <= S_START;
              tx_q  <= 1'b0;
            end else begin
              state <= S_IDLE;
              tx_q  <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          clk_cnt <= '0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx: MSB/LSB order, back-to-back, full FIFO, async reset, loopback
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // default instance: 1 clk/bit, MSB first
  logic       rst_m, valid_m, ready_m, tx_m, busy_m, done_m;
  logic [7:0] data_m;
  logic [2:0] cnt_m;
  // LSB-first instance
  logic       rst_l, valid_l, ready_l, tx_l, busy_l, done_l;
  logic [7:0] data_l;
  logic [2:0] cnt_l;
  // 4 clk/bit instance
  logic       rst_s, valid_s, ready_s, tx_s, busy_s, done_s;
  logic [7:0] data_s;
  logic [2:0] cnt_s;

  uart_tx #(.CLKS_PER_BIT(1), .FIFO_DEPTH(4), .MSB_FIRST(1)) u_dut (
    .i_clk_uart(clk), .i_rst_n(rst_m), .i_data(data_m), .i_valid(valid_m),
    .o_ready(ready_m), .o_tx(tx_m), .o_busy(busy_m), .o_done(done_m), .o_fifo_count(cnt_m));

  uart_tx #(.CLKS_PER_BIT(1), .FIFO_DEPTH(4), .MSB_FIRST(0)) u_lsb (
    .i_clk_uart(clk), .i_rst_n(rst_l), .i_data(data_l), .i_valid(valid_l),
    .o_ready(ready_l), .o_tx(tx_l), .o_busy(busy_l), .o_done(done_l), .o_fifo_count(cnt_l));

  uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .MSB_FIRST(1)) u_slow (
    .i_clk_uart(clk), .i_rst_n(rst_s), .i_data(data_s), .i_valid(valid_s),
    .o_ready(ready_s), .o_tx(tx_s), .o_busy(busy_s), .o_done(done_s), .o_fifo_count(cnt_s));

  logic [7:0] sb_m[$];
  int         done_m_n = 0;
  int         done_l_n = 0;
  int         done_s_n = 0;
  int         rx_n = 0;
  logic [7:0] rx_last = 8'h00;

  always @(negedge clk) begin
    if (done_m === 1'b1) done_m_n++;
    if (done_l === 1'b1) done_l_n++;
    if (done_s === 1'b1) done_s_n++;
  end

  // Receiver model on u_dut's line (1 clk/bit, MSB first): decodes frames and checks them against the scoreboard.
  int         mon_pos = 0;
  logic [7:0] mon_byte = 8'h00;
  logic [7:0] mon_exp;
  always @(negedge clk) begin
    if (rst_m !== 1'b1) begin
      mon_pos <= 0;
    end else if (mon_pos == 0) begin
      if (tx_m === 1'b0) mon_pos <= 1;
    end else if (mon_pos < 9) begin
      mon_byte <= {mon_byte[6:0], tx_m};
      mon_pos  <= mon_pos + 1;
    end else begin
      checks++;
      if (tx_m !== 1'b1) begin
        errors++;
        $display("FAIL rx_stop_bit: got %b want 1", tx_m);
      end
      checks++;
      if (sb_m.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected_byte: got %02h want none", mon_byte);
      end else begin
        mon_exp = sb_m.pop_front();
        if (mon_byte !== mon_exp) begin
          errors++;
          $display("FAIL rx_byte: got %02h want %02h", mon_byte, mon_exp);
        end
      end
      rx_last <= mon_byte;
      rx_n    <= rx_n + 1;
      mon_pos <= 0;
    end
  end

  task automatic test_reset();
    rst_m = 1'b0; rst_l = 1'b0; rst_s = 1'b0;
    valid_m = 1'b0; valid_l = 1'b0; valid_s = 1'b0;
    data_m = 8'h00; data_l = 8'h00; data_s = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (tx_m !== 1'b1)    begin errors++; $display("FAIL reset_tx: got %b want 1", tx_m); end
    checks++; if (busy_m !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy_m); end
    checks++; if (done_m !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b want 0", done_m); end
    checks++; if (cnt_m !== 3'd0)   begin errors++; $display("FAIL reset_count: got %0d want 0", cnt_m); end
    checks++; if (ready_m !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_m); end
    checks++; if (tx_s !== 1'b1)    begin errors++; $display("FAIL reset_tx_slow: got %b want 1", tx_s); end
    rst_m = 1'b1; rst_l = 1'b1; rst_s = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (tx_m !== 1'b1 || busy_m !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: got tx=%b busy=%b want tx=1 busy=0", tx_m, busy_m);
    end
  endtask

  task automatic test_msb_frame();
    logic [10:0] cap, dvec;
    int d0;
    d0 = done_m_n;
    @(negedge clk); data_m = 8'hA5; valid_m = 1'b1; sb_m.push_back(8'hA5);
    @(negedge clk); valid_m = 1'b0;
    checks++; if (cnt_m !== 3'd1 || tx_m !== 1'b1) begin
      errors++; $display("FAIL msb_after_write: got count=%0d tx=%b want count=1 tx=1", cnt_m, tx_m);
    end
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      cap[10-i]  = tx_m;
      dvec[10-i] = done_m;
      if (i == 0) begin
        checks++; if (busy_m !== 1'b1) begin errors++; $display("FAIL msb_busy: got %b want 1", busy_m); end
      end
    end
    checks++; if (cap !== 11'b01010010111) begin errors++; $display("FAIL msb_frame_a5: got %b want 01010010111", cap); end
    checks++; if (dvec !== 11'b00000000010) begin errors++; $display("FAIL msb_done_pos: got %b want 00000000010", dvec); end
    checks++; if (done_m_n - d0 != 1) begin errors++; $display("FAIL msb_done_count: got %0d want 1", done_m_n - d0); end
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL msb_idle_after: got %b want 0", busy_m); end
  endtask

  task automatic test_lsb_frame();
    logic [7:0] bytes [2];
    logic [9:0] exp [2];
    logic [9:0] cap;
    int d0;
    bytes[0] = 8'hA5; exp[0] = 10'b0101001011;
    bytes[1] = 8'h01; exp[1] = 10'b0100000001;
    d0 = done_l_n;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk); data_l = bytes[b]; valid_l = 1'b1;
      @(negedge clk); valid_l = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        cap[9-i] = tx_l;
      end
      checks++; if (cap !== exp[b]) begin
        errors++; $display("FAIL lsb_frame_%02h: got %b want %b", bytes[b], cap, exp[b]);
      end
      @(negedge clk);
    end
    checks++; if (done_l_n - d0 != 2) begin errors++; $display("FAIL lsb_done_count: got %0d want 2", done_l_n - d0); end
  endtask

  task automatic test_back_to_back();
    logic [20:0] cap;
    int d0;
    d0 = done_m_n;
    @(negedge clk); data_m = 8'h00; valid_m = 1'b1; sb_m.push_back(8'h00);
    @(negedge clk); data_m = 8'hFF; sb_m.push_back(8'hFF);
    @(negedge clk); valid_m = 1'b0;
    cap[20] = tx_m;
    for (int i = 1; i < 21; i++) begin
      @(negedge clk);
      cap[20-i] = tx_m;
    end
    checks++; if (cap !== 21'b000000000_1_0_11111111_11) begin
      errors++; $display("FAIL b2b_frames: got %b want 000000000101111111111", cap);
    end
    checks++; if (done_m_n - d0 != 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", done_m_n - d0); end
  endtask

  task automatic test_fifo_full();
    int n, cyc, d0;
    bit saw_full;
    n = 0; cyc = 0; saw_full = 1'b0; d0 = done_m_n;
    while (n < 6 && cyc < 500) begin
      @(negedge clk);
      data_m  = 8'(8'h10 + n);
      valid_m = 1'b1;
      if (cnt_m > 3'd4) begin
        checks++; errors++; $display("FAIL full_count_overflow: got %0d want <=4", cnt_m);
      end
      if (cnt_m == 3'd4) begin
        saw_full = 1'b1;
        checks++; if (ready_m !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", ready_m); end
      end
      if (ready_m === 1'b1) begin
        sb_m.push_back(data_m);
        n++;
      end
      cyc++;
    end
    @(negedge clk); valid_m = 1'b0;
    checks++; if (n != 6) begin errors++; $display("FAIL full_accepted: got %0d want 6", n); end
    checks++; if (!saw_full) begin errors++; $display("FAIL full_reached: got 0 want 1"); end
    cyc = 0;
    while ((sb_m.size() != 0 || busy_m !== 1'b0) && cyc < 1000) begin
      @(negedge clk); cyc++;
    end
    checks++; if (cyc >= 1000) begin errors++; $display("FAIL full_drain_timeout: got %0d left want 0", sb_m.size()); end
    checks++; if (done_m_n - d0 != 6) begin errors++; $display("FAIL full_done_count: got %0d want 6", done_m_n - d0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] f;
    int d0, bad;
    f = 10'b0100000011;
    @(negedge clk); data_s = 8'hA5; valid_s = 1'b1;
    @(negedge clk); data_s = 8'h3C;
    @(negedge clk); valid_s = 1'b0;
    repeat (17) @(negedge clk);
    checks++; if (tx_s !== 1'b0 || busy_s !== 1'b1 || cnt_s !== 3'd1) begin
      errors++; $display("FAIL slow_pre_reset: got tx=%b busy=%b count=%0d want tx=0 busy=1 count=1", tx_s, busy_s, cnt_s);
    end
    d0 = done_s_n;
    #2 rst_s = 1'b0;
    #1;
    checks++; if (tx_s !== 1'b1 || busy_s !== 1'b0 || cnt_s !== 3'd0 || ready_s !== 1'b1 || done_s !== 1'b0) begin
      errors++; $display("FAIL slow_async_reset: got tx=%b busy=%b count=%0d ready=%b done=%b want 1 0 0 1 0",
                         tx_s, busy_s, cnt_s, ready_s, done_s);
    end
    repeat (5) @(negedge clk);
    rst_s = 1'b1;
    repeat (50) @(negedge clk);
    checks++; if (tx_s !== 1'b1 || busy_s !== 1'b0 || done_s_n != d0) begin
      errors++; $display("FAIL slow_quiet_after_reset: got tx=%b busy=%b dones=%0d want 1 0 0", tx_s, busy_s, done_s_n - d0);
    end
    @(negedge clk); data_s = 8'h81; valid_s = 1'b1;
    @(negedge clk); valid_s = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_s !== f[9 - i/4]) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL slow_clean_frame_81: got %0d bad samples want 0", bad); end
    repeat (2) @(negedge clk);
    checks++; if (done_s_n - d0 != 1 || tx_s !== 1'b1) begin
      errors++; $display("FAIL slow_done_count: got %0d tx=%b want 1 tx=1", done_s_n - d0, tx_s);
    end
  endtask

  task automatic test_loopback();
    int n0, cyc;
    n0 = rx_n;
    @(negedge clk); data_m = 8'h3C; valid_m = 1'b1; sb_m.push_back(8'h3C);
    @(negedge clk); data_m = 8'hC3; sb_m.push_back(8'hC3);
    @(negedge clk); valid_m = 1'b0;
    cyc = 0;
    while ((sb_m.size() != 0 || busy_m !== 1'b0) && cyc < 200) begin
      @(negedge clk); cyc++;
    end
    @(negedge clk);
    checks++; if (cyc >= 200) begin errors++; $display("FAIL loop_timeout: got %0d left want 0", sb_m.size()); end
    checks++; if (rx_n - n0 != 2 || rx_last !== 8'hC3) begin
      errors++; $display("FAIL loop_rx: got n=%0d last=%02h want n=2 last=c3", rx_n - n0, rx_last);
    end
  endtask

  initial begin
    test_reset();
    test_msb_frame();
    test_lsb_frame();
    test_back_to_back();
    test_fifo_full();
    test_reset_mid_frame();
    test_loopback();
    repeat (3) @(negedge clk);
    checks++; if (sb_m.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d want 0", sb_m.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
